ex_stage_mc: RTL and testbench

//  Parametrised multi-cycle execute stage; successor to the single-cycle combinational execute block.

---
 rtl/ex_pkg.sv | 34 +++
 rtl/ex_iter_mul.sv | 53 +++++
 rtl/ex_stage_mc.sv | 176 +++++++++++++++++
 tb/tb_ex_stage_mc.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_pkg.sv
// Shared types for the multi-cycle execute stage:
// operation encodings, branch condition codes and FSM states.
package ex_pkg;

    typedef enum logic [3:0] {
        OP_ADD,
        OP_SUB,
        OP_XOR,
        OP_ANDN,
        OP_ROL,
        OP_SLL,
        OP_ROR,
        OP_SRL,
        OP_SEQ,
        OP_SLT,
        OP_SLE,
        OP_SCO,
        OP_BTR,
        OP_LBI,
        OP_SLBI,
        OP_MUL
    } ex_op_t;

    localparam logic [1:0] BR_EQZ = 2'b00;
    localparam logic [1:0] BR_NEZ = 2'b01;
    localparam logic [1:0] BR_LTZ = 2'b10;
    localparam logic [1:0] BR_GEZ = 2'b11;

    typedef enum logic {
        ST_RUN,
        ST_MUL
    } ex_state_t;

endpackage

// File: rtl/ex_iter_mul.sv
// Iterative shift-add multiplier, one partial product per cycle.
// done holds with a stable product until the next start.
module ex_iter_mul #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              done,
    output logic [DATA_W-1:0] prod
);
    localparam int CW = $clog2(DATA_W);

    logic [DATA_W-1:0] acc_q;
    logic [DATA_W-1:0] mcand_q;
    logic [DATA_W-1:0] mplier_q;
    logic [CW-1:0]     cnt_q;
    logic              busy_q;
    logic              last;
    logic [DATA_W-1:0] step_sum;

    assign last     = (cnt_q == CW'(DATA_W - 1));
    assign step_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

    // The final partial product is added combinationally, so the
    // result is ready during the cycle where cnt reaches DATA_W-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else if (start) begin
            acc_q    <= '0;
            mcand_q  <= a;
            mplier_q <= b;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
        end else if (busy_q && !last) begin
            acc_q    <= step_sum;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 1'b1;
        end
    end

    assign done = busy_q && last;
    assign prod = step_sum;

endmodule

// File: rtl/ex_stage_mc.sv
// Multi-cycle execute stage: op mux, branch check, iterative
// multiply and a registered output slot with valid/ready on both sides.
module ex_stage_mc
    import ex_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter bit MUL_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  ex_op_t            op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b_reg,
    input  logic [DATA_W-1:0] imm,
    input  logic              imm_sel,
    input  logic              br_en,
    input  logic [1:0]        br_typ,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_branch,
    output logic              out_ofl
);
    localparam int SH_W = $clog2(DATA_W);
    localparam int HALF = DATA_W / 2;
    localparam int MSB  = DATA_W - 1;

    ex_state_t           state_q;
    logic                valid_q;
    logic [DATA_W-1:0]   data_q;
    logic                branch_q;
    logic                ofl_q;
    logic                mul_br_q;

    logic [DATA_W-1:0]   b_op;
    logic [DATA_W:0]     sum;
    logic [DATA_W-1:0]   diff;
    logic [SH_W-1:0]     sh;
    logic [2*DATA_W-1:0] rot_l;
    logic [2*DATA_W-1:0] rot_r;
    logic [DATA_W-1:0]   btr;
    logic [DATA_W-1:0]   res;
    logic                res_ofl;
    logic                cond;
    logic                br_bit;
    logic                is_mul;
    logic                accept;
    logic                pop;
    logic                mul_done;
    logic [DATA_W-1:0]   mul_prod;

    assign b_op  = imm_sel ? imm : b_reg;
    assign sum   = {1'b0, a} + {1'b0, b_op};
    assign diff  = b_op - a;
    assign sh    = SH_W'(32'(b_op[SH_W-1:0]) % DATA_W);
    assign rot_l = {a, a} << sh;
    assign rot_r = {a, a} >> sh;

    always_comb begin
        btr = '0;
        for (int i = 0; i < DATA_W; i++) begin
            btr[i] = a[MSB-i];
        end
    end

    always_comb begin
        res     = '0;
        res_ofl = 1'b0;
        unique case (op)
            OP_ADD: begin
                res     = sum[MSB:0];
                res_ofl = (a[MSB] == b_op[MSB]) && (sum[MSB] != a[MSB]);
            end
            OP_SUB: begin
                res     = diff;
                res_ofl = (a[MSB] != b_op[MSB]) && (diff[MSB] != b_op[MSB]);
            end
            OP_XOR:  res = a ^ b_op;
            OP_ANDN: res = a & ~b_op;
            OP_ROL:  res = rot_l[2*DATA_W-1:DATA_W];
            OP_SLL:  res = a << sh;
            OP_ROR:  res = rot_r[DATA_W-1:0];
            OP_SRL:  res = a >> sh;
            OP_SEQ:  res = DATA_W'(a == b_op);
            OP_SLT:  res = DATA_W'($signed(a) < $signed(b_op));
            OP_SLE:  res = DATA_W'($signed(a) <= $signed(b_op));
            OP_SCO:  res = DATA_W'(sum[DATA_W]);
            OP_BTR:  res = btr;
            OP_LBI:  res = b_op;
            OP_SLBI: res = (a << HALF) | {{HALF{1'b0}}, b_op[HALF-1:0]};
            default: res = '0;
        endcase
    end

    always_comb begin
        cond = 1'b0;
        unique case (br_typ)
            BR_EQZ:  cond = (a == '0);
            BR_NEZ:  cond = (a != '0);
            BR_LTZ:  cond = a[MSB];
            BR_GEZ:  cond = !a[MSB];
            default: cond = 1'b0;
        endcase
    end

    assign br_bit   = br_en && cond;
    assign is_mul   = (op == OP_MUL) && MUL_EN;
    assign in_ready = (state_q == ST_RUN) && !flush && (!valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign pop      = valid_q && out_ready;

    ex_iter_mul #(
        .DATA_W (DATA_W)
    ) u_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .start (accept && is_mul),
        .a     (a),
        .b     (b_op),
        .done  (mul_done),
        .prod  (mul_prod)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_RUN;
            valid_q  <= 1'b0;
            data_q   <= '0;
            branch_q <= 1'b0;
            ofl_q    <= 1'b0;
            mul_br_q <= 1'b0;
        end else if (flush) begin
            valid_q <= 1'b0;
            state_q <= ST_RUN;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (pop) valid_q <= 1'b0;
                    if (accept) begin
                        if (is_mul) begin
                            state_q  <= ST_MUL;
                            mul_br_q <= br_bit;
                        end else begin
                            valid_q  <= 1'b1;
                            data_q   <= res;
                            branch_q <= br_bit;
                            ofl_q    <= res_ofl;
                        end
                    end
                end
                ST_MUL: begin
                    // Product waits here until the slot can take it.
                    if (mul_done && (!valid_q || out_ready)) begin
                        valid_q  <= 1'b1;
                        data_q   <= mul_prod;
                        branch_q <= mul_br_q;
                        ofl_q    <= 1'b0;
                        state_q  <= ST_RUN;
                    end else if (pop) begin
                        valid_q <= 1'b0;
                    end
                end
                default: state_q <= ST_RUN;
            endcase
        end
    end

    assign out_valid  = valid_q;
    assign out_data   = data_q;
    assign out_branch = branch_q;
    assign out_ofl    = ofl_q;

endmodule

// File: tb/tb_ex_stage_mc.sv
// Self-checking bench for ex_stage_mc: directed cases plus
// randomized traffic against a transaction-level reference model.
module tb_ex_stage_mc;
    import ex_pkg::*;

    localparam int     W     = 16;
    localparam longint MASK  = (longint'(1) << W) - 1;
    localparam longint SHM   = longint'(1) << $clog2(W);
    localparam longint S_MAX = (longint'(1) << (W - 1)) - 1;
    localparam longint S_MIN = -(longint'(1) << (W - 1));

    logic         clk = 1'b0;
    logic         rst_n;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    ex_op_t       op = OP_ADD;
    logic [W-1:0] a = '0;
    logic [W-1:0] b_reg = '0;
    logic [W-1:0] imm = '0;
    logic         imm_sel = 1'b0;
    logic         br_en = 1'b0;
    logic [1:0]   br_typ = 2'b00;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_data;
    logic         out_branch;
    logic         out_ofl;

    ex_stage_mc #(
        .DATA_W (W),
        .MUL_EN (1'b1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op         (op),
        .a          (a),
        .b_reg      (b_reg),
        .imm        (imm),
        .imm_sel    (imm_sel),
        .br_en      (br_en),
        .br_typ     (br_typ),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_branch (out_branch),
        .out_ofl    (out_ofl)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    bit     m_valid, m_busy, m_br, m_ofl, p_br;
    int     m_left;
    longint m_data, p_data;
    bit     ir_seen;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic longint sx(input longint v);
        return v[W-1] ? v - (longint'(1) << W) : v;
    endfunction

    function automatic void calc(input ex_op_t o, input longint x,
                                 input longint y, output longint r,
                                 output bit ov);
        longint t;
        int     s;
        s  = int'((y % SHM) % W);
        r  = 0;
        ov = 1'b0;
        case (o)
            OP_ADD: begin
                r  = (x + y) & MASK;
                t  = sx(x) + sx(y);
                ov = (t > S_MAX) || (t < S_MIN);
            end
            OP_SUB: begin
                r  = (y - x) & MASK;
                t  = sx(y) - sx(x);
                ov = (t > S_MAX) || (t < S_MIN);
            end
            OP_XOR:  r = x ^ y;
            OP_ANDN: r = x & ~y & MASK;
            OP_ROL:  r = ((x << s) | (x >> (W - s))) & MASK;
            OP_SLL:  r = (x << s) & MASK;
            OP_ROR:  r = ((x >> s) | (x << (W - s))) & MASK;
            OP_SRL:  r = x >> s;
            OP_SEQ:  r = (sx(x) == sx(y)) ? 1 : 0;
            OP_SLT:  r = (sx(x) < sx(y)) ? 1 : 0;
            OP_SLE:  r = (sx(x) <= sx(y)) ? 1 : 0;
            OP_SCO:  r = (x + y) >> W;
            OP_BTR: begin
                for (int i = 0; i < W; i++)
                    r = r | (((x >> i) & 1) << (W - 1 - i));
            end
            OP_LBI:  r = y;
            OP_SLBI: r = ((x << (W / 2)) | (y & ((longint'(1) << (W / 2)) - 1))) & MASK;
            OP_MUL:  r = (x * y) & MASK;
            default: r = 0;
        endcase
    endfunction

    function automatic bit br_ref(input bit en, input logic [1:0] typ,
                                  input longint x);
        if (!en) return 1'b0;
        case (typ)
            2'b00:   return x == 0;
            2'b01:   return x != 0;
            2'b10:   return sx(x) < 0;
            default: return sx(x) >= 0;
        endcase
    endfunction

    task automatic model_reset();
        m_valid = 0; m_busy = 0; m_br = 0; m_ofl = 0;
        m_left = 0; m_data = 0; p_data = 0; p_br = 0;
    endtask

    // Advance the model by one clock edge using the inputs just sampled.
    task automatic model_step(input bit exp_ir);
        longint bv, r;
        bit     ov;
        bv = imm_sel ? longint'(imm) : longint'(b_reg);
        if (flush) begin
            m_valid = 0;
            m_busy  = 0;
        end else if (m_busy) begin
            if (m_left > 0) begin
                m_left--;
                if (m_valid && out_ready) m_valid = 0;
            end else if (!m_valid || out_ready) begin
                m_valid = 1; m_data = p_data; m_br = p_br;
                m_ofl = 0; m_busy = 0;
            end
        end else begin
            if (m_valid && out_ready) m_valid = 0;
            if (in_valid && exp_ir) begin
                calc(op, longint'(a), bv, r, ov);
                if (op == OP_MUL) begin
                    m_busy = 1; m_left = W - 1;
                    p_data = r; p_br = br_ref(br_en, br_typ, longint'(a));
                end else begin
                    m_valid = 1; m_data = r; m_ofl = ov;
                    m_br = br_ref(br_en, br_typ, longint'(a));
                end
            end
        end
    endtask

    task automatic cyc(input logic v, input ex_op_t o, input logic [W-1:0] ai,
                       input logic [W-1:0] bi, input logic [W-1:0] im,
                       input logic isel, input logic ben, input logic [1:0] bt,
                       input logic ordy, input logic fl);
        bit exp_ir;
        @(negedge clk);
        chk("out_valid", out_valid, m_valid);
        if (m_valid) begin
            chk("out_data", out_data, m_data);
            chk("out_branch", out_branch, m_br);
            chk("out_ofl", out_ofl, m_ofl);
        end
        in_valid = v; op = o; a = ai; b_reg = bi; imm = im;
        imm_sel = isel; br_en = ben; br_typ = bt;
        out_ready = ordy; flush = fl;
        #1;
        exp_ir = !m_busy && !flush && (!m_valid || out_ready);
        ir_seen = in_ready;
        chk("in_ready", in_ready, exp_ir);
        @(posedge clk);
        model_step(exp_ir);
    endtask

    task automatic idle(input logic ordy);
        cyc(1'b0, OP_ADD, '0, '0, '0, 1'b0, 1'b0, 2'b00, ordy, 1'b0);
    endtask

    initial begin
        longint r;
        bit     ov;
        int     stall;

        calc(OP_ADD, 64'h7FFF, 64'h1, r, ov);
        chk("model_add", {r[62:0], ov}, {63'h8000, 1'b1});
        calc(OP_ROR, 64'h0001, 64'h0011, r, ov);
        chk("model_ror", r, 64'h8000);
        calc(OP_SUB, 64'h0003, 64'h0001, r, ov);
        chk("model_sub", r, 64'hFFFE);

        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_branch", out_branch, 0);
        chk("rst_ofl", out_ofl, 0);
        chk("rst_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;

        cyc(1, OP_ADD, 16'h7FFF, 16'h0001, 0, 0, 0, 2'b00, 1, 0);
        #2;
        chk("add_ofl_data", out_data, 16'h8000);
        chk("add_ofl_flag", out_ofl, 1);
        chk("add_ofl_valid", out_valid, 1);

        cyc(1, OP_SLBI, 16'h00AB, 16'h1234, 16'h00CD, 1, 0, 2'b00, 1, 0);
        #2 chk("slbi", out_data, 16'hABCD);
        cyc(1, OP_BTR, 16'h0001, 0, 0, 0, 0, 2'b00, 1, 0);
        #2 chk("btr", out_data, 16'h8000);

        cyc(1, OP_MUL, 16'h0003, 16'hFFFF, 0, 0, 0, 2'b00, 1, 0);
        stall = 0;
        for (int i = 0; i < W; i++) begin
            idle(1);
            if (!ir_seen) stall++;
            if (i == W - 2) #2 chk("mul_not_early", out_valid, 0);
        end
        chk("mul_stall_cycles", stall, 16);
        #2;
        chk("mul_data", out_data, 16'hFFFD);
        chk("mul_valid", out_valid, 1);

        cyc(1, OP_ADD, 16'h0001, 16'h0002, 0, 0, 0, 2'b00, 0, 0);
        chk("hold_in_ready", ir_seen, 0);
        idle(0);
        idle(0);
        #2 chk("hold_data", out_data, 16'hFFFD);
        cyc(1, OP_ADD, 16'h0001, 16'h0002, 0, 0, 0, 2'b00, 1, 0);
        #2 chk("b2b_first", out_data, 16'h0003);
        cyc(1, OP_ADD, 16'h0004, 16'h0005, 0, 0, 0, 2'b00, 1, 0);
        #2 chk("b2b_second", out_data, 16'h0009);
        chk("b2b_valid", out_valid, 1);

        cyc(1, OP_MUL, 16'h0005, 16'h0007, 0, 0, 0, 2'b00, 1, 0);
        repeat (4) idle(1);
        cyc(0, OP_ADD, 0, 0, 0, 0, 0, 2'b00, 1, 1);
        #2 chk("flush_valid", out_valid, 0);
        cyc(1, OP_SEQ, 16'h0005, 16'h0005, 0, 0, 0, 2'b00, 1, 0);
        chk("flush_run_ready", ir_seen, 1);
        #2 chk("seq_after_flush", out_data, 16'h0001);

        cyc(1, OP_ADD, 16'h8000, 0, 0, 0, 1, 2'b10, 1, 0);
        #2 chk("br_ltz", out_branch, 1);
        cyc(1, OP_ADD, 16'h0000, 0, 0, 0, 1, 2'b11, 1, 0);
        #2 chk("br_gez", out_branch, 1);
        cyc(1, OP_ADD, 16'h0005, 0, 0, 0, 1, 2'b00, 1, 0);
        #2 chk("br_eqz_nz", out_branch, 0);
        cyc(1, OP_ADD, 16'h0005, 0, 0, 0, 0, 2'b01, 1, 0);
        #2 chk("br_disabled", out_branch, 0);

        cyc(1, OP_ADD, 16'h0005, 16'h0001, 0, 0, 1, 2'b01, 1, 0);
        cyc(1, OP_MUL, 16'h0003, 16'h0003, 0, 0, 1, 2'b11, 0, 0);
        repeat (3) idle(0);
        #3 rst_n = 1'b0;
        #1;
        chk("rstmul_valid", out_valid, 0);
        chk("rstmul_data", out_data, 0);
        chk("rstmul_branch", out_branch, 0);
        chk("rstmul_ofl", out_ofl, 0);
        chk("rstmul_in_ready", in_ready, 1);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1, OP_SEQ, 16'h0005, 16'h0005, 0, 0, 0, 2'b00, 1, 0);
        #2 chk("rstmul_after", out_data, 16'h0001);

        for (int n = 0; n < 3000; n++) begin
            logic [W-1:0] ra, rb;
            ra = W'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? ra : W'($urandom);
            cyc($urandom_range(0, 9) < 7,
                ex_op_t'(4'($urandom_range(0, 15))),
                ra, rb, W'($urandom), 1'($urandom), 1'($urandom),
                2'($urandom), $urandom_range(0, 9) < 6,
                $urandom_range(0, 19) == 0);
        end
        idle(1);
        idle(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
